// File: rtl/mux_row_sequencer_lut.sv
`default_nettype none
// ============================================================================
//  Module   : mux_row_sequencer_lut
//  Purpose  : Drives the one-hot multiplexing-row enables for the LED drivers.
//             A programmable all-off gap separates consecutive rows. Also
//             returns a registered lookup from driver output index to
//             physical LED row, for the row whose data is being loaded.
//  Revision : 1.0 - initial release
// ============================================================================
module mux_row_sequencer_lut #(
   parameter  int NB_LEDS_PER_GROUP = 16,
   parameter  int NB_LED_ROWS       = 32,
   parameter  int NB_MUX_ROWS       = 4,
   parameter  int DEAD_CYCLES       = 2,
   localparam int LED_WIDTH         = $clog2(NB_LEDS_PER_GROUP),
   localparam int LED_ROW_WIDTH     = $clog2(NB_LED_ROWS)
) (
   input  logic                     clk,
   input  logic                     nrst,
   input  logic                     enable,
   input  logic                     mode,
   input  logic                     advance,
   output logic [NB_MUX_ROWS-1:0]   mux_en,
   input  logic                     lut_valid,
   input  logic [LED_WIDTH-1:0]     led,
   output logic [LED_ROW_WIDTH-1:0] led_row,
   output logic                     row_valid,
   output logic                     overrun
);

   localparam int MUX_WIDTH = $clog2(NB_MUX_ROWS);
   localparam int BANKS     = NB_LED_ROWS / NB_LEDS_PER_GROUP;
   // A zero-length gap still costs one blank cycle, so the counter never
   // runs for fewer than one cycle.
   localparam int DEAD_LEN  = (DEAD_CYCLES < 1) ? 1 : DEAD_CYCLES;
   localparam int CNT_W     = $clog2(DEAD_LEN + 1);

   localparam logic [MUX_WIDTH-1:0] LAST_ROW  = MUX_WIDTH'(NB_MUX_ROWS - 1);
   localparam logic [CNT_W-1:0]     DEAD_LAST = CNT_W'(DEAD_LEN - 1);
   localparam logic [31:0]          BANKS_U   = 32'(BANKS);
   localparam logic [31:0]          GROUP_U   = 32'(NB_LEDS_PER_GROUP);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DEAD   = 2'd1,
      S_ACTIVE = 2'd2
   } state_t;

   state_t                   state_q, state_d;
   logic [MUX_WIDTH-1:0]     cur_q, cur_d;
   logic [MUX_WIDTH-1:0]     tgt_q, tgt_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     overrun_q, overrun_d;
   logic [LED_ROW_WIDTH-1:0] led_row_q, led_row_d;
   logic                     row_valid_q;
   logic [MUX_WIDTH-1:0]     lrow_w;
   logic [31:0]              bank_w;
   logic [31:0]              led_ext_w;

   // Sequencer state register.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q   <= S_IDLE;
         cur_q     <= '0;
         tgt_q     <= '0;
         cnt_q     <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cur_q     <= cur_d;
         tgt_q     <= tgt_d;
         cnt_q     <= cnt_d;
         overrun_q <= overrun_d;
      end
   end

   // Next-state logic: enable low overrides everything and parks in IDLE.
   always_comb begin
      state_d   = state_q;
      cur_d     = cur_q;
      tgt_d     = tgt_q;
      cnt_d     = cnt_q;
      overrun_d = overrun_q;
      if (!enable) begin
         if (advance) overrun_d = 1'b1;
         state_d = S_IDLE;
         cur_d   = '0;
         tgt_d   = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (advance) begin
                  tgt_d   = '0;
                  cnt_d   = '0;
                  state_d = S_DEAD;
               end
            end
            S_DEAD: begin
               if (advance) overrun_d = 1'b1;
               if (cnt_q == DEAD_LAST) begin
                  cnt_d   = '0;
                  cur_d   = tgt_q;
                  state_d = S_ACTIVE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_ACTIVE: begin
               if (advance) begin
                  tgt_d   = (cur_q == LAST_ROW) ? '0 : cur_q + 1'b1;
                  cnt_d   = '0;
                  state_d = S_DEAD;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // One-hot row enable, decoded from registered state only.
   always_comb begin
      mux_en = '0;
      if (state_q == S_ACTIVE) mux_en[cur_q] = 1'b1;
   end

   // Row whose data is being loaded, then its driver-index -> LED-row map.
   always_comb begin
      case (state_q)
         S_ACTIVE: lrow_w = (cur_q == LAST_ROW) ? '0 : cur_q + 1'b1;
         S_DEAD:   lrow_w = (tgt_q == LAST_ROW) ? '0 : tgt_q + 1'b1;
         default:  lrow_w = '0;
      endcase
      bank_w    = 32'(lrow_w) % BANKS_U;
      led_ext_w = 32'(led);
      if (led_ext_w >= GROUP_U) begin
         led_row_d = '0;
      end else if (mode) begin
         led_row_d = LED_ROW_WIDTH'(led_ext_w * BANKS_U + bank_w);
      end else begin
         led_row_d = LED_ROW_WIDTH'(bank_w * GROUP_U + led_ext_w);
      end
   end

   // Lookup result register; holds its value between requests.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         led_row_q   <= '0;
         row_valid_q <= 1'b0;
      end else begin
         row_valid_q <= lut_valid;
         if (lut_valid) led_row_q <= led_row_d;
      end
   end

   assign led_row   = led_row_q;
   assign row_valid = row_valid_q;
   assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_row_sequencer_lut.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_row_sequencer_lut
//  Purpose  : Self-checking bench for mux_row_sequencer_lut (default build and
//             a zero-gap build side by side) against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mux_row_sequencer_lut;

   localparam int GROUP = 16;
   localparam int LROWS = 32;
   localparam int NMUX  = 4;
   localparam int BANKS = LROWS / GROUP;

   logic       clk;
   logic       nrst;
   logic       enable;
   logic       mode;
   logic       advance;
   logic       lut_valid;
   logic [3:0] led;

   logic [3:0] mux_en, mux_en0;
   logic [4:0] led_row, led_row0;
   logic       row_valid, row_valid0;
   logic       overrun, overrun0;

   int n_checks;
   int n_fail;

   // Behavioural model, index 0 = default build, 1 = zero-gap build.
   // phase: 0 idle, 1 blank, 2 showing
   int m_phase [2];
   int m_row   [2];
   int m_next  [2];
   int m_left  [2];
   int m_ovr   [2];
   int m_lrow  [2];
   int m_rv    [2];
   int blank_len [2] = '{2, 1};

   mux_row_sequencer_lut #(
      .NB_LEDS_PER_GROUP(GROUP), .NB_LED_ROWS(LROWS),
      .NB_MUX_ROWS(NMUX), .DEAD_CYCLES(2)
   ) u_dut (
      .clk(clk), .nrst(nrst), .enable(enable), .mode(mode),
      .advance(advance), .mux_en(mux_en), .lut_valid(lut_valid),
      .led(led), .led_row(led_row), .row_valid(row_valid), .overrun(overrun)
   );

   mux_row_sequencer_lut #(
      .NB_LEDS_PER_GROUP(GROUP), .NB_LED_ROWS(LROWS),
      .NB_MUX_ROWS(NMUX), .DEAD_CYCLES(0)
   ) u_dut0 (
      .clk(clk), .nrst(nrst), .enable(enable), .mode(mode),
      .advance(advance), .mux_en(mux_en0), .lut_valid(lut_valid),
      .led(led), .led_row(led_row0), .row_valid(row_valid0), .overrun(overrun0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_phase[k] = 0; m_row[k] = 0; m_next[k] = 0; m_left[k] = 0;
         m_ovr[k] = 0; m_lrow[k] = 0; m_rv[k] = 0;
      end
   endtask

   // Applies the current inputs to the model as one clock edge.
   task automatic model_edge();
      int lr, b;
      for (int k = 0; k < 2; k++) begin
         m_rv[k] = lut_valid;
         if (lut_valid) begin
            if (m_phase[k] == 0)      lr = 0;
            else if (m_phase[k] == 2) lr = (m_row[k] + 1) % NMUX;
            else                      lr = (m_next[k] + 1) % NMUX;
            b = lr % BANKS;
            if (mode) m_lrow[k] = (int'(led) * BANKS + b) % LROWS;
            else      m_lrow[k] = (b * GROUP + int'(led)) % LROWS;
         end
         if (!enable) begin
            if (advance) m_ovr[k] = 1;
            m_phase[k] = 0; m_row[k] = 0; m_next[k] = 0; m_left[k] = 0;
         end else if (m_phase[k] == 0) begin
            if (advance) begin
               m_next[k] = 0; m_phase[k] = 1; m_left[k] = blank_len[k];
            end
         end else if (m_phase[k] == 1) begin
            if (advance) m_ovr[k] = 1;
            m_left[k] = m_left[k] - 1;
            if (m_left[k] == 0) begin
               m_row[k] = m_next[k]; m_phase[k] = 2;
            end
         end else begin
            if (advance) begin
               m_next[k] = (m_row[k] + 1) % NMUX; m_phase[k] = 1; m_left[k] = blank_len[k];
            end
         end
      end
   endtask

   function automatic int exp_mux(input int k);
      return (m_phase[k] == 2) ? (1 << m_row[k]) : 0;
   endfunction

   task automatic compare_all();
      check_eq("mux_en",     32'(mux_en),     32'(exp_mux(0)));
      check_eq("overrun",    32'(overrun),    32'(m_ovr[0]));
      check_eq("row_valid",  32'(row_valid),  32'(m_rv[0]));
      check_eq("led_row",    32'(led_row),    32'(m_lrow[0]));
      check_eq("mux_en_z",   32'(mux_en0),    32'(exp_mux(1)));
      check_eq("overrun_z",  32'(overrun0),   32'(m_ovr[1]));
      check_eq("row_valid_z",32'(row_valid0), 32'(m_rv[1]));
      check_eq("led_row_z",  32'(led_row0),   32'(m_lrow[1]));
   endtask

   // One clock: drive inputs (at negedge), edge, then compare at next negedge.
   task automatic cyc(input logic en, input logic adv, input logic lv,
                      input logic md, input logic [3:0] ld);
      enable = en; advance = adv; lut_valid = lv; mode = md; led = ld;
      model_edge();
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      nrst = 1'b0; enable = 1'b0; advance = 1'b0; lut_valid = 1'b0;
      mode = 1'b0; led = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check_eq("rst_mux_en",    32'(mux_en),    32'd0);
      check_eq("rst_row_valid", 32'(row_valid), 32'd0);
      check_eq("rst_led_row",   32'(led_row),   32'd0);
      check_eq("rst_overrun",   32'(overrun),   32'd0);
      nrst = 1'b1;

      // Start-up: three edges to row 0 (one blank cycle in the zero-gap build)
      cyc(1, 1, 0, 0, 0);
      check_eq("seq_e1", 32'(mux_en), 32'd0);
      check_eq("z_e1",   32'(mux_en0), 32'd0);
      cyc(1, 0, 0, 0, 0);
      check_eq("seq_e2", 32'(mux_en), 32'd0);
      check_eq("z_e2",   32'(mux_en0), 32'b0001);
      cyc(1, 0, 0, 0, 0);
      check_eq("seq_e3", 32'(mux_en), 32'b0001);

      // Lookup while showing row 0: next row is 1 (bank 1)
      cyc(1, 0, 1, 0, 5);
      check_eq("map_m0", 32'(led_row), 32'd21);
      check_eq("map_rv", 32'(row_valid), 32'd1);
      cyc(1, 0, 1, 1, 5);
      check_eq("map_m1", 32'(led_row), 32'd11);
      cyc(1, 0, 0, 1, 7);
      check_eq("map_hold", 32'(led_row), 32'd11);

      // Walk rows 1,2,3,0; last advance coincides with a lookup at cur=3
      for (int r = 1; r <= 4; r++) begin
         cyc(1, 1, logic'(r == 4), 0, 5);
         check_eq("seq_blank1", 32'(mux_en), 32'd0);
         if (r == 4) check_eq("wrap_lookup", 32'(led_row), 32'd5);
         cyc(1, 0, 0, 0, 0);
         check_eq("seq_blank2", 32'(mux_en), 32'd0);
         cyc(1, 0, 0, 0, 0);
         check_eq("seq_row", 32'(mux_en), 32'(1 << (r % NMUX)));
      end

      // Overrun: advance while blanking is ignored and sticks
      cyc(1, 1, 0, 0, 0);
      cyc(1, 1, 0, 0, 0);
      check_eq("ovr_set", 32'(overrun), 32'd1);
      cyc(1, 0, 0, 0, 0);
      check_eq("ovr_seq", 32'(mux_en), 32'b0010);
      repeat (3) cyc(1, 0, 0, 0, 0);
      check_eq("ovr_sticky", 32'(overrun), 32'd1);

      // Abort during blanking, lookup while idle, then restart at row 0
      cyc(1, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      check_eq("abort_mux", 32'(mux_en), 32'd0);
      cyc(0, 0, 1, 0, 15);
      check_eq("idle_map", 32'(led_row), 32'd15);
      cyc(1, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      check_eq("restart_row0", 32'(mux_en), 32'b0001);

      // Asynchronous reset while showing a row, with a result pending
      cyc(1, 0, 1, 0, 3);
      #2 nrst = 1'b0;
      #1;
      check_eq("arst_mux_en",    32'(mux_en),    32'd0);
      check_eq("arst_row_valid", 32'(row_valid), 32'd0);
      check_eq("arst_overrun",   32'(overrun),   32'd0);
      model_reset();
      @(negedge clk);
      nrst = 1'b1;

      // Randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         cyc(logic'(($urandom % 16) != 0), logic'(($urandom % 4) == 0),
             logic'($urandom % 2), logic'($urandom % 2), 4'($urandom % 16));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
